pyc_sync_mem_pipe: RTL
======================

Name: pyc_sync_mem_pipe

Overview:
Parametrised successor to the team's single-stage 1R1W synchronous memory. Adds configurable read latency with a read-valid output, a selectable read-during-write policy, and a built-in post-reset clear sequencer that zeroes the array. It sits behind core-side load/store units and scratchpads wherever a memory with deterministic contents after reset and a retimed read path is needed.

Parameters:
ADDR_WIDTH, 64, address port width in bits.
DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
DEPTH, 1024, number of entries; must be >= 1.
RD_LATENCY, 1, cycles from ren to rvalid/rdata; legal range 1..4.
RDW_MODE, 0, same-address read-during-write policy: 0 = write-first, 1 = read-first.
CLEAR_ON_RESET, 1, 1 = zero every entry after reset; 0 = no clear, block is usable immediately.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
ren  in  1  read request.
raddr  in  ADDR_WIDTH  read address, in entries.
rdata  out  DATA_WIDTH  read data, valid when rvalid=1.
rvalid  out  1  read data valid, one pulse per accepted read.
wvalid  in  1  write request.
waddr  in  ADDR_WIDTH  write address, in entries.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
init_busy  out  1  clear sequence in progress; requests are ignored while high.
oor_err  out  1  sticky flag: an out-of-range access occurred since reset.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - rdata=0, rvalid=0, oor_err=0.
  - All pipeline valid bits are cleared.
  - Clear pointer=0.
  - FSM=CLEAR if CLEAR_ON_RESET=1, else RUN; init_busy=1 in CLEAR.
  - Array contents are not touched by the asynchronous reset itself.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - After the cycle that writes mem[DEPTH-1], the FSM goes to RUN and init_busy drops. init_busy is therefore high for exactly DEPTH cycles after reset release.
  - RUN persists until the next rst.
- In CLEAR, ren and wvalid are ignored entirely: no array write, no rvalid, no oor_err.
- Reset asserted mid-CLEAR restarts the clear from entry 0. Reset mid-read discards all in-flight reads; no rvalid is produced for them.
- Read pipeline:
  - A read accepted at edge t (RUN, ren=1) samples the array at edge t.
  - rvalid=1 and rdata are presented after edge t+RD_LATENCY-1, i.e. RD_LATENCY=1 matches the single-stage block.
  - Stages 2..RD_LATENCY are plain registers. There is no backpressure; back-to-back reads give back-to-back rvalid.
  - Data is captured at array-read time. Writes issued after that do not alter in-flight data.
  - rdata holds its last value while rvalid=0.
- Writes: synchronous; only bytes with wstrb[i]=1 are updated. wstrb=0 with wvalid=1 is a no-op.
- Read-during-write, same cycle, same in-range address:
  - RDW_MODE=0: returned word = old word with the strobed bytes replaced by wdata.
  - RDW_MODE=1: returned word = old word.
- Range check: the full ADDR_WIDTH address is compared against DEPTH; no truncation.
  - Write with waddr >= DEPTH: dropped, oor_err set.
  - Read with raddr >= DEPTH: still returns rvalid=1 with rdata=0, oor_err set.
  - oor_err clears only on rst.
- Simultaneous in-range read and write to different addresses: independent, no interaction.

Decomposition:
- Shared package pyc_mem_pkg holds:
  - RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1;
  - FSM state encodings ST_CLEAR and ST_RUN;
  - a byte-merge function (old, new, strb) -> merged word, reused by the write path and the write-first forwarding.
- One sub-module, pyc_pipe_delay: a parametrised valid+data delay line with depth RD_LATENCY-1 and asynchronous clear of the valid bits. It is instantiated for stages 2..RD_LATENCY; at depth 0 it is a pass-through.

Test Plan:
- Reset release with DEPTH=16, CLEAR_ON_RESET=1 -> init_busy high exactly 16 cycles; a ren issued during busy gives no rvalid; after busy, reads of addresses 0..15 all return 0.
- RD_LATENCY=3: write 0xDEADBEEF_CAFEF00D to addr 5, then ren addr 5 at cycle t -> rvalid pulses once, after edge t+2, with that data; 4 back-to-back reads of addrs 5,6,5,6 give 4 consecutive rvalid cycles in order.
- Same-cycle write to addr 7 with wdata=0x1111…11, wstrb=0x0F, while reading addr 7 whose old value is 0xAAAA…AA -> RDW_MODE=0 returns 0xAAAAAAAA_11111111; RDW_MODE=1 returns 0xAAAA…AA; a follow-up read returns 0xAAAAAAAA_11111111 in both modes.
- Write to addr DEPTH (1024) -> array unchanged and oor_err=1. Read of addr 2^40 -> rvalid=1, rdata=0; oor_err remains 1 until rst.
- Assert rst at clear cycle 8 of 16 -> init_busy stays high, clear restarts at 0, busy for 16 more cycles after release. Assert rst while a RD_LATENCY=4 read is in flight -> no rvalid after release.
- Byte strobes: write 0x0102030405060708 with wstrb=0xFF, then wdata=0xFF…FF with wstrb=0x81 -> read returns 0xFF020304050607FF.

Source files
------------

// File: rtl/pyc_mem_pkg.sv
// pyc_mem_pkg: shared read-during-write codes, FSM states and byte-merge helper for pyc_sync_mem_pipe
package pyc_mem_pkg;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST = 1;
  localparam int MAX_DW = 1024;
  localparam int MAX_BW = MAX_DW / 8;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} st_e;
  // Widest supported word; callers size-cast arguments and result to their own width.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_BW-1:0] strb);
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BW; i++) if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/pyc_pipe_delay.sv
// pyc_pipe_delay: valid+data delay line; data only advances behind a valid so the output holds between pulses
module pyc_pipe_delay #(
  parameter int STAGES = 0,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  localparam int N = STAGES > 0 ? STAGES : 1;
  logic v_q [N];
  logic v_d [N];
  logic [W-1:0] d_q [N];
  logic [W-1:0] d_d [N];
  always_comb begin
    v_d[0] = in_valid;
    d_d[0] = in_valid ? in_data : d_q[0];
    for (int i = 1; i < N; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  assign out_valid = STAGES == 0 ? in_valid : v_q[N-1];
  assign out_data = STAGES == 0 ? in_data : d_q[N-1];
endmodule

// File: rtl/pyc_sync_mem_pipe.sv
// pyc_sync_mem_pipe: 1R1W synchronous memory with post-reset clear, configurable read latency and RDW policy
module pyc_sync_mem_pipe
  import pyc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    wvalid,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    init_busy,
  output logic                    oor_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_WIDTH > 32 ? ADDR_WIDTH + 1 : 33;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  st_e st_q, st_d;
  logic busy_q, busy_d, oor_q, oor_d, rv1_q, rv1_d;
  logic [IW-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, old_w, wr_w;
  logic run, r_in, w_in, rd_acc, wr_en, clr_last;
  // Range check uses the full address widened past DEPTH so high address bits never alias.
  always_comb begin
    run = st_q == ST_RUN;
    r_in = CW'(raddr) < CW'(DEPTH);
    w_in = CW'(waddr) < CW'(DEPTH);
    rd_acc = run && ren;
    wr_en = run && wvalid && w_in;
    clr_last = clr_ptr_q == IW'(DEPTH - 1);
    old_w = r_in ? mem[IW'(raddr)] : '0;
    wr_w = DATA_WIDTH'(byte_merge(MAX_DW'(mem[IW'(waddr)]), MAX_DW'(wdata), MAX_BW'(wstrb)));
    st_d = (run || clr_last) ? ST_RUN : ST_CLEAR;
    busy_d = st_d == ST_CLEAR;
    clr_ptr_d = run ? clr_ptr_q : clr_ptr_q + 1'b1;
    oor_d = oor_q || (run && ((ren && !r_in) || (wvalid && !w_in)));
    rv1_d = rd_acc;
    rd1_d = !rd_acc ? rd1_q
          : (RDW_MODE == RDW_WRITE_FIRST && wr_en && waddr == raddr) ? wr_w : old_w;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_RUN;
      busy_q <= CLEAR_ON_RESET != 0;
      clr_ptr_q <= '0;
      oor_q <= 1'b0;
      rv1_q <= 1'b0;
      rd1_q <= '0;
    end else begin
      st_q <= st_d;
      busy_q <= busy_d;
      clr_ptr_q <= clr_ptr_d;
      oor_q <= oor_d;
      rv1_q <= rv1_d;
      rd1_q <= rd1_d;
    end
  // The array has no reset; rst only blocks writes while it is held.
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) mem[clr_ptr_q] <= '0;
      else if (wr_en) mem[IW'(waddr)] <= wr_w;
    end
  pyc_pipe_delay #(.STAGES(RD_LATENCY - 1), .W(DATA_WIDTH)) u_dly (
    .clk(clk),
    .rst(rst),
    .in_valid(rv1_q),
    .in_data(rd1_q),
    .out_valid(rvalid),
    .out_data(rdata)
  );
  assign init_busy = busy_q;
  assign oor_err = oor_q;
endmodule
